// File: rtl/t_ctrl_pkg.sv
// Shared encodings for the T flip-flop counter/controller.
package t_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/t_ff_arst.sv
// Single T flip-flop cell with asynchronous active-high reset.
module t_ff_arst (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  // Toggle on t, clear immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 1'b0;
    else if (t) q <= ~q;
  end

endmodule

// File: rtl/t_ff_counter_ctrl.sv
// Programmable divide-by-(div_val+1) counter built from a chain of T-FF cells.
// The controller never loads the count; it only steers per-bit toggle enables
// to increment, wrap or clear the chain.
module t_ff_counter_ctrl
  import t_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] div_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] term;
  logic             mode_q;
  logic [WIDTH-1:0] t;
  logic             wrap;

  assign wrap = (count == term);

  // Toggle enables: clearing toggles every set bit, incrementing toggles
  // each bit whose lower bits are all ones (ripple-carry pattern).
  always_comb begin
    logic carry;
    t     = '0;
    carry = 1'b1;
    if (state == ST_RUN) begin
      if (stop || wrap) begin
        t = count;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          t[i]  = carry;
          carry = carry & count[i];
        end
      end
    end
  end

  // The T-FF chain holding the count.
  for (genvar g = 0; g < WIDTH; g++) begin : g_chain
    t_ff_arst u_tff (
      .clk  (clk),
      .reset(reset),
      .t    (t[g]),
      .q    (count[g])
    );
  end

  // Start/stop sequencing with registered tick, done and busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      term   <= '0;
      mode_q <= 1'b0;
      busy   <= 1'b0;
      tick   <= 1'b0;
      done   <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state  <= ST_RUN;
            term   <= div_val;
            mode_q <= mode;
            busy   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (wrap) begin
            tick <= 1'b1;
            if (mode_q == MODE_ONESHOT) begin
              done  <= 1'b1;
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t_ff_counter_ctrl.sv
// Scoreboard bench for t_ff_counter_ctrl: the stimulus process predicts each
// cycle's outputs with an integer model and queues them; a monitor compares.
module tb_t_ff_counter_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] div_val = '0;
  logic [WIDTH-1:0] count;
  logic             tick, busy, done;

  typedef struct {
    int cnt;
    bit tick;
    bit busy;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit m_running = 0;
  int m_cnt = 0;
  int m_term = 0;
  bit m_oneshot = 0;

  t_ff_counter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .stop   (stop),
    .mode   (mode),
    .div_val(div_val),
    .count  (count),
    .tick   (tick),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_running = 0;
    m_cnt     = 0;
    m_term    = 0;
    m_oneshot = 0;
  endtask

  // Drive one cycle of inputs, then predict the post-edge outputs.
  task automatic step(input bit st, input bit sp, input bit md, input int dv);
    exp_t e;
    @(negedge clk);
    start   = st;
    stop    = sp;
    mode    = md;
    div_val = dv[WIDTH-1:0];
    @(posedge clk);
    e.tick = 0;
    e.done = 0;
    if (!m_running) begin
      if (st && !sp) begin
        m_running = 1;
        m_term    = dv % (1 << WIDTH);
        m_oneshot = md;
        m_cnt     = 0;
      end
    end else if (sp) begin
      m_running = 0;
      m_cnt     = 0;
    end else if (m_cnt == m_term) begin
      m_cnt  = 0;
      e.tick = 1;
      if (m_oneshot) begin
        e.done    = 1;
        m_running = 0;
      end
    end else begin
      m_cnt = m_cnt + 1;
    end
    e.cnt  = m_cnt;
    e.busy = m_running;
    exp_q.push_back(e);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // Monitor: compare the DUT against each queued prediction after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", int'(count), e.cnt);
        check("tick", int'(tick), int'(e.tick));
        check("busy", int'(busy), int'(e.busy));
        check("done", int'(done), int'(e.done));
      end
    end
  end

  initial begin
    // Reset held with start requested: block must stay cleared.
    start   = 1'b1;
    div_val = 4'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_count", int'(count), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_done", int'(done), 0);
    end
    start = 1'b0;
    reset = 1'b0;
    model_reset();
    step(0, 0, 0, 5);

    // Continuous divide-by-4, three full periods then stop.
    step(1, 0, 0, 3);
    idle_steps(12);
    step(0, 1, 0, 0);

    // One-shot divide-by-6, then quiet period.
    step(1, 0, 1, 5);
    idle_steps(6);
    idle_steps(10);

    // start and stop together: stop wins.
    step(1, 1, 0, 4);
    idle_steps(2);

    // term=0 continuous; a mid-run start must be ignored.
    step(1, 0, 0, 0);
    idle_steps(3);
    step(1, 0, 1, 9);
    idle_steps(4);
    step(0, 1, 0, 0);

    // One-shot with term=0.
    step(1, 0, 1, 0);
    idle_steps(3);

    // Stop at count 2, then stop coinciding with a wrap.
    step(1, 0, 0, 7);
    idle_steps(2);
    step(0, 1, 0, 0);
    idle_steps(2);
    step(1, 0, 0, 7);
    idle_steps(7);
    step(0, 1, 0, 0);
    idle_steps(2);

    // Full-range wrap 15 -> 0.
    step(1, 0, 0, 15);
    idle_steps(17);

    // Asynchronous reset between edges while count is 9.
    step(0, 1, 0, 0);
    step(1, 0, 0, 15);
    idle_steps(9);
    #3;
    reset = 1'b1;
    #1;
    check("async_count", int'(count), 0);
    check("async_busy", int'(busy), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)));
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
